// File: rtl/nrzi_unstuff_if.sv
// rtl/nrzi_unstuff_if.sv - line-side sample inputs and decoded-bit outputs of the NRZI unstuffer
interface nrzi_unstuff_if;
  logic       d_plus;
  logic       shift_enable;
  logic       eop;
  logic       d_orig;
  logic       d_valid;
  logic       stuff_err;
  logic [3:0] ones_run;

  modport master (
    output d_plus,
    output shift_enable,
    output eop,
    input  d_orig,
    input  d_valid,
    input  stuff_err,
    input  ones_run
  );

  modport slave (
    input  d_plus,
    input  shift_enable,
    input  eop,
    output d_orig,
    output d_valid,
    output stuff_err,
    output ones_run
  );
endinterface

// File: rtl/nrzi_unstuff.sv
// rtl/nrzi_unstuff.sv - NRZI decoder with bit-unstuffing; removal of stuffed bits is built only with NRZI_UNSTUFF_EN
module nrzi_unstuff #(
  parameter int   STUFF_RUN  = 6,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          n_rst,
  nrzi_unstuff_if.slave bus
);

  if (STUFF_RUN < 2 || STUFF_RUN > 15) begin : g_bad_stuff_run
    $error("nrzi_unstuff: STUFF_RUN must lie in 2..15");
  end

  logic       last_level_q, last_level_d;
  logic       d_orig_q,     d_orig_d;
  logic       d_valid_q,    d_valid_d;
  logic       stuff_err_q,  stuff_err_d;
  logic [3:0] ones_run_q,   ones_run_d;
  logic       raw_bit;

  // An unchanged line level decodes to 1, a transition to 0.
  assign raw_bit = ~(bus.d_plus ^ last_level_q);

`ifdef NRZI_UNSTUFF_EN
  localparam logic [3:0] STUFF_RUN_W = 4'(STUFF_RUN);

  always_comb begin
    last_level_d = last_level_q;
    d_orig_d     = d_orig_q;
    d_valid_d    = 1'b0;
    stuff_err_d  = 1'b0;
    ones_run_d   = ones_run_q;
    if (bus.shift_enable) begin
      if (bus.eop) begin
        last_level_d = IDLE_LEVEL;
        ones_run_d   = 4'd0;
      end else begin
        last_level_d = bus.d_plus;
        if (ones_run_q == STUFF_RUN_W) begin
          // Bit after a full run is the stuffed 0; a 1 here is a violation.
          stuff_err_d = raw_bit;
          ones_run_d  = 4'd0;
        end else begin
          d_valid_d  = 1'b1;
          d_orig_d   = raw_bit;
          ones_run_d = raw_bit ? ones_run_q + 4'd1 : 4'd0;
        end
      end
    end
  end
`else
  always_comb begin
    last_level_d = last_level_q;
    d_orig_d     = d_orig_q;
    d_valid_d    = 1'b0;
    stuff_err_d  = 1'b0;
    ones_run_d   = ones_run_q;
    if (bus.shift_enable) begin
      if (bus.eop) begin
        last_level_d = IDLE_LEVEL;
        ones_run_d   = 4'd0;
      end else begin
        last_level_d = bus.d_plus;
        d_valid_d    = 1'b1;
        d_orig_d     = raw_bit;
        if (!raw_bit) begin
          ones_run_d = 4'd0;
        end else if (ones_run_q != 4'hF) begin
          ones_run_d = ones_run_q + 4'd1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_level_q <= IDLE_LEVEL;
      d_orig_q     <= 1'b1;
      d_valid_q    <= 1'b0;
      stuff_err_q  <= 1'b0;
      ones_run_q   <= 4'd0;
    end else begin
      last_level_q <= last_level_d;
      d_orig_q     <= d_orig_d;
      d_valid_q    <= d_valid_d;
      stuff_err_q  <= stuff_err_d;
      ones_run_q   <= ones_run_d;
    end
  end

  assign bus.d_orig    = d_orig_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.stuff_err = stuff_err_q;
  assign bus.ones_run  = ones_run_q;

endmodule

// File: tb/tb_nrzi_unstuff.sv
// tb/tb_nrzi_unstuff.sv - scoreboard bench for nrzi_unstuff (default or NRZI_UNSTUFF_EN build)
module tb_nrzi_unstuff;

`ifdef NRZI_UNSTUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif
  localparam int   RUN  = 6;
  localparam logic IDLE = 1'b1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  nrzi_unstuff_if bus ();

  nrzi_unstuff #(.STUFF_RUN(RUN), .IDLE_LEVEL(IDLE)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       d_orig;
    logic       d_valid;
    logic       stuff_err;
    logic [3:0] ones_run;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  logic       m_last  = IDLE;
  logic       m_dorig = 1'b1;
  logic [3:0] m_ones  = 4'd0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_d_orig"},    {3'b0, bus.d_orig},    {3'b0, e.d_orig});
      check({e.tag, "_d_valid"},   {3'b0, bus.d_valid},   {3'b0, e.d_valid});
      check({e.tag, "_stuff_err"}, {3'b0, bus.stuff_err}, {3'b0, e.stuff_err});
      check({e.tag, "_ones_run"},  bus.ones_run,          e.ones_run);
    end
  endtask

  task automatic strobe(input logic dp, input logic e, input string tag);
    exp_t x;
    logic raw;
    @(negedge clk);
    bus.d_plus       = dp;
    bus.eop          = e;
    bus.shift_enable = 1'b1;
    x.d_valid   = 1'b0;
    x.stuff_err = 1'b0;
    if (e) begin
      m_last = IDLE;
      m_ones = 4'd0;
    end else begin
      raw    = ~(dp ^ m_last);
      m_last = dp;
      if (STUFF_EN && m_ones == 4'(RUN)) begin
        x.stuff_err = raw;
        m_ones      = 4'd0;
      end else begin
        x.d_valid = 1'b1;
        m_dorig   = raw;
        m_ones    = !raw ? 4'd0 : (m_ones == 4'hF ? 4'hF : m_ones + 4'd1);
      end
    end
    x.d_orig   = m_dorig;
    x.ones_run = m_ones;
    x.tag      = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    bus.shift_enable = 1'b0;
    bus.eop          = 1'b0;
    sb_check();
  endtask

  task automatic strobe_bit(input logic raw, input string tag);
    strobe(raw ? m_last : ~m_last, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.shift_enable = 1'b0;
      bus.d_plus       = $urandom_range(0, 1);
      bus.eop          = $urandom_range(0, 1);
      x.d_orig    = m_dorig;
      x.d_valid   = 1'b0;
      x.stuff_err = 1'b0;
      x.ones_run  = m_ones;
      x.tag       = tag;
      sb.push_back(x);
      @(posedge clk);
      #1;
      bus.eop = 1'b0;
      sb_check();
    end
  endtask

  logic exp27 [5];
  logic dp27  [5];

  initial begin
    bus.d_plus       = IDLE;
    bus.shift_enable = 1'b0;
    bus.eop          = 1'b0;
    exp27 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    dp27  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_d_orig",    {3'b0, bus.d_orig},    4'd1);
    check("reset_d_valid",   {3'b0, bus.d_valid},   4'd0);
    check("reset_stuff_err", {3'b0, bus.stuff_err}, 4'd0);
    check("reset_ones_run",  bus.ones_run,          4'd0);
    n_rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      strobe(dp27[i], 1'b0, "basic");
      check("basic_literal_d_orig", {3'b0, bus.d_orig}, {3'b0, exp27[i]});
    end

    strobe(1'b0, 1'b1, "eop_low");
    check("eop_no_valid", {3'b0, bus.d_valid}, 4'd0);
    strobe(1'b1, 1'b0, "after_eop");
    check("after_eop_decodes_1", {3'b0, bus.d_orig}, 4'd1);

    idle(3, "idle");

    strobe(1'b0, 1'b1, "run6_eop");
    for (int i = 0; i < 6; i++) strobe_bit(1'b1, "run6_ones");
    check("run6_count", bus.ones_run, 4'd6);
    strobe_bit(1'b0, "run6_zero");

    strobe(1'b0, 1'b1, "run7_eop");
    for (int i = 0; i < 7; i++) strobe_bit(1'b1, "run7_ones");
    idle(1, "run7_after");

    strobe(1'b0, 1'b1, "eopwin_eop");
    for (int i = 0; i < 6; i++) strobe_bit(1'b1, "eopwin_ones");
    strobe(1'b1, 1'b1, "eopwin_at_stuff");
    check("eopwin_no_err", {3'b0, bus.stuff_err}, 4'd0);

    strobe(1'b0, 1'b1, "sat_eop");
    for (int i = 0; i < 17; i++) strobe_bit(1'b1, "sat_ones");

    strobe(1'b0, 1'b1, "rst_eop");
    for (int i = 0; i < 4; i++) strobe_bit(1'b1, "rst_ones");
    strobe_bit(1'b0, "rst_zero");
    #1 n_rst = 1'b0;
    #1;
    check("async_rst_d_orig",    {3'b0, bus.d_orig},    4'd1);
    check("async_rst_d_valid",   {3'b0, bus.d_valid},   4'd0);
    check("async_rst_stuff_err", {3'b0, bus.stuff_err}, 4'd0);
    check("async_rst_ones_run",  bus.ones_run,          4'd0);
    #1 n_rst = 1'b1;
    m_last  = IDLE;
    m_dorig = 1'b1;
    m_ones  = 4'd0;
    strobe(1'b0, 1'b0, "post_rst");
    check("post_rst_decodes_0", {3'b0, bus.d_orig}, 4'd0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), "rand_idle");
      if ($urandom_range(0, 15) == 0) strobe($urandom_range(0, 1), 1'b1, "rand_eop");
      else strobe_bit($urandom_range(0, 4) != 0, "rand_bit");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/nrzi_unstuff.md
NRZI_UNSTUFF -- requirements
Module: nrzi_unstuff

Interface
REQ-001 Parameter STUFF_RUN, default 6, count of consecutive decoded 1s after which one stuffed bit follows; legal range 2..15.
REQ-002 Parameter IDLE_LEVEL, default 1'b1, line level assumed at reset and after EOP.
REQ-003 Port clk  input  1  system clock, all state updates on the rising edge.
REQ-004 Port n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port d_plus  input  1  synchronised NRZI line level.
REQ-006 Port shift_enable  input  1  single-cycle strobe marking the bit-centre sample point.
REQ-007 Port eop  input  1  end-of-packet indication, qualified by shift_enable.
REQ-008 Port d_orig  output  1  decoded, unstuffed data bit.
REQ-009 Port d_valid  output  1  one-cycle pulse; d_orig carries a new payload bit.
REQ-010 Port stuff_err  output  1  one-cycle pulse; a stuff violation was detected.
REQ-011 Port ones_run  output  4  current count of consecutive decoded 1s.

Function
REQ-012 A sample event is a cycle with shift_enable=1; cycles with shift_enable=0 change no state, and d_valid and stuff_err read 0 in the following cycle.
REQ-013 On a sample event with eop=0, raw bit b = NOT(d_plus XOR last_level); last_level takes the value of d_plus.
REQ-014 On a sample event with eop=1, last_level takes IDLE_LEVEL, ones_run clears to 0, no bit is produced, and d_valid and stuff_err read 0 next cycle.
REQ-015 Latency: d_orig, d_valid, stuff_err and ones_run are registered and update exactly one clock after the sample event.
REQ-016 With ones_run < STUFF_RUN: a payload bit is produced; d_orig=b, d_valid=1; ones_run increments if b=1, else clears to 0.
REQ-017 With ones_run == STUFF_RUN and b=0: stuffed bit; d_valid=0, d_orig holds, ones_run clears to 0.
REQ-018 With ones_run == STUFF_RUN and b=1: violation; stuff_err=1, d_valid=0, d_orig holds, ones_run clears to 0.
REQ-019 ones_run never exceeds STUFF_RUN; the upper bits are zero when STUFF_RUN < 15.
REQ-020 d_orig holds its last value in every cycle where d_valid=0.
REQ-021 If eop and a stuff-position sample coincide, eop wins: no stuff_err, no d_valid.
REQ-022 Back-to-back sample events on consecutive clocks are supported at full rate.

Reset
REQ-023 While n_rst=0: last_level=IDLE_LEVEL, d_orig=1, d_valid=0, stuff_err=0, ones_run=0, independent of clk.
REQ-024 Reset assertion mid-packet discards the partial stuff run; the first sample event after release decodes against IDLE_LEVEL.

Configuration
REQ-025 Macro NRZI_UNSTUFF_EN compiled in: REQ-016 to REQ-019 and REQ-021 apply as written.
REQ-026 Macro NRZI_UNSTUFF_EN absent: every non-EOP sample event yields d_valid=1 with d_orig=b, stuff_err is tied to 0, ones_run still counts consecutive 1s saturating at 15, and the port list is unchanged.

Verification
REQ-027 Reset, then samples with d_plus=1,1,0,0,1 (eop=0) -> d_orig=1,1,0,1,0 with d_valid=1 each, one clock after each strobe.
REQ-028 Six decoded 1s then decoded 0 (line held, then toggled) -> six valid 1s, ones_run reaches 6, seventh sample gives d_valid=0, ones_run=0, d_orig stays 1.
REQ-029 Seven decoded 1s -> seventh sample gives stuff_err=1 for one cycle, d_valid=0, ones_run=0.
REQ-030 Strobe with eop=1 while d_plus=0, then strobe with d_plus=1, eop=0 -> first yields no d_valid; second decodes 1 against IDLE_LEVEL.
REQ-031 Four 1s decoded, then n_rst pulsed low asynchronously between edges -> outputs at reset values immediately; next sample with d_plus=0 decodes 0.
REQ-032 Build without NRZI_UNSTUFF_EN, eight decoded 1s -> eight d_valid pulses, stuff_err never asserted, ones_run=8.
